fp16_stream_accumulator: RTL and testbench

- Sequential reduction stage that feeds and consumes the team's combinational fp16 adder.
- Accepts a valid/ready stream of fp16 words delimited by a last flag.
- Holds the running sum in a register and drives the adder with the running sum and the incoming word each cycle.
- Emits one fp16 reduction result per packet on a valid/ready output, together with the element count and a length-error flag.

---
 rtl/fp16_stream_accumulator.sv | 143 ++++++++++++++
 tb/tb_fp16_stream_accumulator.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp16_stream_accumulator.sv
// -----------------------------------------------------------------------------
// fp16_stream_accumulator
//
// Reduces a valid/ready stream of fp16 words into one fp16 sum per packet.
// Packets are delimited by in_last. The block does no fp arithmetic itself.
// It drives an external combinational fp16 adder with the running sum (acc)
// and the incoming word, and it captures the adder result on accept cycles.
// A packet that reaches MAX_LEN words without in_last is closed early, and
// that result is flagged with out_len_err.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   in_valid        input word valid
//   in_ready        block can accept a word (low only while a result is held)
//   in_data         fp16 input word
//   in_last         final word of the packet (ignored when in_valid=0)
//   add_operand_a   adder operand a, always the acc register
//   add_operand_b   adder operand b, always in_data (pass-through)
//   add_sum         adder result for the two operands above
//   out_valid       result valid
//   out_ready       downstream accepts the result
//   out_data        fp16 reduction result
//   out_count       number of elements accumulated into out_data
//   out_len_err     packet was truncated at MAX_LEN
// -----------------------------------------------------------------------------
module fp16_stream_accumulator #(
   parameter int MAX_LEN = 256,
   parameter int CNT_W   = $clog2(MAX_LEN + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in_data,
   input  logic             in_last,
   output logic [15:0]      add_operand_a,
   output logic [15:0]      add_operand_b,
   input  logic [15:0]      add_sum,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [15:0]      out_data,
   output logic [CNT_W-1:0] out_count,
   output logic             out_len_err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LEN);

   state_t           state;
   state_t           state_nxt;
   logic [15:0]      acc;
   logic [CNT_W-1:0] cnt;
   logic             len_err;

   logic             accept;
   logic [15:0]      acc_nxt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             trunc;
   logic             term;

   // in_ready is a pure state decode, so out_ready never reaches it combinationally.
   assign in_ready      = (state != DONE);
   assign accept        = in_valid && in_ready;
   assign add_operand_a = acc;
   assign add_operand_b = in_data;

   // Next-state and candidate register values for an accept this cycle.
   always_comb begin
      state_nxt = state;
      // The first word bypasses the adder, so a one-word packet comes back
      // bit-exact (including -0 and subnormal encodings).
      acc_nxt   = (state == IDLE) ? in_data : add_sum;
      cnt_nxt   = (state == IDLE) ? CNT_W'(1) : cnt + CNT_W'(1);
      // MAX_LEN >= 2, so the length limit can only be reached in ACCUM.
      trunc     = (state == ACCUM) && !in_last && (cnt_nxt == MAX_CNT);
      term      = in_last || trunc;

      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = in_last ? DONE : ACCUM;
            end
         end
         ACCUM: begin
            if (accept && term) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Accumulator, element counter and the registered result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc         <= 16'h0000;
         cnt         <= '0;
         len_err     <= 1'b0;
         out_valid   <= 1'b0;
         out_data    <= 16'h0000;
         out_count   <= '0;
         out_len_err <= 1'b0;
      end else begin
         if (accept) begin
            acc     <= acc_nxt;
            cnt     <= cnt_nxt;
            len_err <= len_err | trunc;
            // The result registers load on the same edge that accepts the
            // terminating word, so out_valid rises with no extra latency.
            if (term) begin
               out_valid   <= 1'b1;
               out_data    <= acc_nxt;
               out_count   <= cnt_nxt;
               out_len_err <= len_err | trunc;
            end
         end else if ((state == DONE) && out_ready) begin
            out_valid <= 1'b0;
            acc       <= 16'h0000;
            cnt       <= '0;
            len_err   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fp16_stream_accumulator.sv
// -----------------------------------------------------------------------------
// tb_fp16_stream_accumulator
//
// Bench for fp16_stream_accumulator with MAX_LEN=4. A behavioural fp16 adder
// closes the add_operand/add_sum loop. It converts to real, adds, and rounds
// back, saturating at 0x7BFF. Expected results are queued as each packet is
// driven. A monitor pops one entry on every output handshake.
// -----------------------------------------------------------------------------
module tb_fp16_stream_accumulator;

   localparam int MAX_LEN = 4;
   localparam int CNT_W   = $clog2(MAX_LEN + 1);

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [15:0]      in_data;
   logic             in_last;
   logic [15:0]      add_operand_a;
   logic [15:0]      add_operand_b;
   logic [15:0]      add_sum;
   logic             out_valid;
   logic             out_ready;
   logic [15:0]      out_data;
   logic [CNT_W-1:0] out_count;
   logic             out_len_err;

   typedef struct packed {
      logic [15:0]      data;
      logic [CNT_W-1:0] cnt;
      logic             err;
   } res_t;

   res_t sb[$];
   res_t exp_r;
   int   n_assert;
   int   n_fail;

   fp16_stream_accumulator #(.MAX_LEN(MAX_LEN)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .in_last      (in_last),
      .add_operand_a(add_operand_a),
      .add_operand_b(add_operand_b),
      .add_sum      (add_sum),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_count    (out_count),
      .out_len_err  (out_len_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural fp16 adder ----------------
   function automatic real pow2(input int n);
      real r;
      r = 1.0;
      if (n >= 0) begin
         for (int i = 0; i < n; i++) r = r * 2.0;
      end else begin
         for (int i = 0; i < -n; i++) r = r / 2.0;
      end
      return r;
   endfunction

   function automatic real to_real(input logic [15:0] h);
      real v;
      if (h[14:10] == 5'd0) v = real'(h[9:0]) * pow2(-24);
      else                  v = real'({1'b1, h[9:0]}) * pow2(int'(h[14:10]) - 25);
      return h[15] ? -v : v;
   endfunction

   function automatic logic [15:0] to_fp16(input real r);
      logic s;
      real  a;
      real  mag;
      int   ex;
      int   be;
      int   m;
      s   = (r < 0.0);
      mag = s ? -r : r;
      a   = mag;
      if (mag == 0.0) return 16'h0000;
      if (mag >= 65520.0) return {s, 15'h7BFF};
      ex = 0;
      while (a >= 2.0) begin a = a / 2.0; ex++; end
      while (a < 1.0) begin a = a * 2.0; ex--; end
      be = ex + 15;
      if (be < 1) begin
         m = int'(mag * pow2(24));
         if (m == 0) return 16'h0000;
         return {s, 15'(m)};
      end
      m = int'((a - 1.0) * 1024.0);
      if (m == 1024) begin m = 0; be++; end
      if (be >= 31) return {s, 15'h7BFF};
      return {s, be[4:0], m[9:0]};
   endfunction

   always_comb add_sum = to_fp16(to_real(add_operand_a) + to_real(add_operand_b));

   // ---------------- checking ----------------
   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic res_t mk(input logic [15:0] d, input int c, input logic e);
      res_t r;
      r.data = d;
      r.cnt  = CNT_W'(c);
      r.err  = e;
      return r;
   endfunction

   // Scoreboard monitor: a handshake completes on the next rising edge.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         check_eq("sb_has_entry", 32'(sb.size() > 0), 32'd1);
         if (sb.size() > 0) begin
            exp_r = sb.pop_front();
            check_eq("out_data", 32'(out_data), 32'(exp_r.data));
            check_eq("out_count", 32'(out_count), 32'(exp_r.cnt));
            check_eq("out_len_err", 32'(out_len_err), 32'(exp_r.err));
         end
      end
   end

   // ---------------- stimulus helpers (called at posedge+1) ----------------
   task automatic send(input logic [15:0] d, input logic last);
      int n;
      n        = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 50) check_eq("in_ready_timeout", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic idle_in();
      in_valid = 1'b0;
      in_last  = 1'b1;
      in_data  = 16'($urandom);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() > 0 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check_eq("drain_done", 32'(sb.size()), 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      n_assert  = 0;
      n_fail    = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = 16'h0000;
      in_last   = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("rst_out_data", 32'(out_data), 32'd0);
      check_eq("rst_out_count", 32'(out_count), 32'd0);
      check_eq("rst_out_len_err", 32'(out_len_err), 32'd0);
      check_eq("rst_acc", 32'(add_operand_a), 32'd0);
      rst     = 1'b0;
      in_data = 16'h1234;
      @(posedge clk); #1;
      check_eq("in_ready_after_rst", 32'(in_ready), 32'd1);
      check_eq("operand_b_pass", 32'(add_operand_b), 32'h1234);

      // 1 + 2 + 3 = 6
      out_ready = 1'b1;
      sb.push_back(mk(16'h4600, 3, 1'b0));
      send(16'h3C00, 1'b0);
      send(16'h4000, 1'b0);
      check_eq("operand_a_acc", 32'(add_operand_a), 32'h4200);
      send(16'h4200, 1'b1);
      check_eq("latency_valid", 32'(out_valid), 32'd1);
      idle_in();
      drain();

      // Single -0 word held under backpressure
      out_ready = 1'b0;
      sb.push_back(mk(16'h8000, 1, 1'b0));
      send(16'h8000, 1'b1);
      idle_in();
      repeat (5) begin
         @(negedge clk);
         check_eq("hold_valid", 32'(out_valid), 32'd1);
         check_eq("hold_data", 32'(out_data), 32'h8000);
         check_eq("hold_count", 32'(out_count), 32'd1);
         check_eq("hold_in_ready", 32'(in_ready), 32'd0);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check_eq("released_valid", 32'(out_valid), 32'd0);
      check_eq("released_in_ready", 32'(in_ready), 32'd1);
      drain();

      // Cancellation and saturation
      sb.push_back(mk(16'h0000, 2, 1'b0));
      send(16'h3C00, 1'b0);
      send(16'hBC00, 1'b1);
      sb.push_back(mk(16'h7BFF, 2, 1'b0));
      send(16'h7BFF, 1'b0);
      send(16'h7BFF, 1'b1);
      idle_in();
      drain();

      // Truncation at MAX_LEN=4; the fifth word starts a new packet
      sb.push_back(mk(16'h4400, 4, 1'b1));
      sb.push_back(mk(16'h3C00, 1, 1'b0));
      for (int i = 0; i < 4; i++) send(16'h3C00, 1'b0);
      check_eq("trunc_latency_valid", 32'(out_valid), 32'd1);
      send(16'h3C00, 1'b1);
      idle_in();
      drain();

      // Asynchronous reset mid-packet after two accepted words
      send(16'h3C00, 1'b0);
      send(16'h4000, 1'b0);
      idle_in();
      check_eq("pre_rst_acc", 32'(add_operand_a), 32'h4200);
      #3 rst = 1'b1;
      #1;
      check_eq("async_rst_acc", 32'(add_operand_a), 32'd0);
      check_eq("async_rst_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // Asynchronous reset while a result is held; that result is discarded
      out_ready = 1'b0;
      send(16'h4000, 1'b1);
      idle_in();
      check_eq("held_before_rst", 32'(out_valid), 32'd1);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check_eq("rst_drops_valid", 32'(out_valid), 32'd0);
      check_eq("rst_clears_data", 32'(out_data), 32'd0);
      @(posedge clk); #1;
      rst       = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      sb.push_back(mk(16'h4000, 1, 1'b0));
      send(16'h4000, 1'b1);
      idle_in();
      drain();

      check_eq("sb_empty_end", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
